fpga_config_loader: RTL and testbench
=====================================

// Module: fpga_config_loader
// PURPOSE
//  Synthesizable bitstream loader for the fpga fabric. Replaces the bench-only file-read
//  config sequence. Accepts configuration frames over a valid/ready stream and writes
//  each frame into the fabric with configs_in/configs_en. After the last frame it
//  enables the fabric flip-flops (ff_en), then raises rdy. Sits between the bitstream
//  source (ROM/SPI/host) and the fpga top's configs_in/configs_en/ff_en ports.
// PARAMETERS
//  DATA_W      320  frame width; equals the fpga configs_in width
//  NUM_FRAMES  172  number of config rows; equals the fpga configs_en width
//  PRE_WAIT    10   idle cycles after start before the first frame is accepted (>=1)
//  POST_WAIT   10   cycles after the last frame write before ff_en rises (>=1)
//  RDY_DELAY   10   cycles after ff_en rises before rdy rises (>=1)
// PORTS
//  clock       input   1           single clock, rising edge
//  rst         input   1           synchronous, active-low reset
//  start       input   1           1-cycle pulse: begin or restart a load
//  bs_data     input   DATA_W      frame data
//  bs_valid    input   1           frame data is valid
//  bs_last     input   1           marks the final frame; qualified by bs_valid
//  bs_ready    output  1           loader accepts a frame this cycle
//  configs_in  output  DATA_W      registered frame data to the fabric
//  configs_en  output  NUM_FRAMES  one-hot row write strobe; otherwise all 0
//  ff_en       output  1           fabric flip-flop enable
//  rdy         output  1           configuration complete, fabric running
//  busy        output  1           load in progress (PRE_WAIT..ENABLE)
//  err         output  1           frame count mismatch; sticky until start/reset
// BEHAVIOUR
//  - Reset (rst==0 at a clock edge): state=IDLE, frame index=0, counters=0. All outputs 0.
//  - States: IDLE, PRE, FETCH, SETUP, WRITE, POST, ENABLE, READY, ERROR.
//  - IDLE: start -> PRE. Other inputs ignored.
//  - PRE: count PRE_WAIT cycles -> FETCH.
//  - FETCH: bs_ready=1. On a bs_valid&&bs_ready edge: capture bs_data into configs_in,
//    latch bs_last, go to SETUP. bs_ready is 0 in every other state.
//  - SETUP: one cycle. configs_in is stable and configs_en is all 0.
//  - WRITE: one cycle. configs_en = 1<<idx and configs_in is held. Exit depends on:
//      idx==NUM_FRAMES-1 && last  -> POST
//      idx<NUM_FRAMES-1 && !last  -> idx++, FETCH
//      any other combination      -> ERROR (short or long stream); that row is still written
//  - Throughput: at least 3 cycles per frame (FETCH/SETUP/WRITE). bs_valid stalls extend FETCH.
//  - POST: count POST_WAIT cycles -> ENABLE. ff_en is set to 1 on the ENABLE entry edge.
//  - ENABLE: count RDY_DELAY cycles with ff_en=1 -> READY. rdy is set to 1 on the READY entry edge.
//  - READY: ff_en=1, rdy=1, held indefinitely.
//  - ERROR: err=1, ff_en=0, rdy=0. The fabric never runs on a partial bitstream.
//  - busy=1 in PRE, FETCH, SETUP, WRITE, POST and ENABLE.
//  - start in READY or ERROR: restart. On the next edge ff_en, rdy and err go to 0,
//    idx=0, state=PRE.
//  - start while busy: ignored. An in-flight load is never aborted by start.
//  - Reset mid-load: immediate return to IDLE. ff_en and rdy drop on that edge. configs_en=0.
//  - configs_en is never multi-hot. configs_in changes only on a FETCH accept or on reset.
//  - The frame index register is $clog2(NUM_FRAMES) wide. There is no wrap: reaching
//    NUM_FRAMES-1 always exits to POST or ERROR.
//  - All outputs are registered. There is no combinational path from inputs to outputs.
// TESTING
//  (bench params: DATA_W=8, NUM_FRAMES=4, PRE_WAIT=2, POST_WAIT=3, RDY_DELAY=2)
//  1 Reset: rst=0 for 3 cycles with start=1 -> all outputs 0 and no bs_ready.
//  2 Nominal: start, then frames 8'hA1,A2,A3,A4 (last on A4) with bs_valid held
//    -> configs_en pulses 0001,0010,0100,1000 with configs_in=A1..A4 during each pulse.
//    ff_en rises 3 cycles after the 1000 pulse; rdy rises 2 cycles later. err=0 throughout.
//  3 Backpressure: bs_valid toggles 1/0 every cycle -> same write sequence and data as
//    scenario 2. bs_ready is high only in FETCH. No frame is duplicated or dropped.
//  4 Short stream: bs_last on frame 2 (8'hA2) -> configs_en pulses 0001 then 0010, then
//    err=1, ff_en=0, rdy=0 held. A later start clears err and reloads.
//  5 Long stream: bs_last=0 on the 4th frame -> 4 writes, then err=1 and ff_en stays 0.
//  6 Restart/reset: start pulses during FETCH are ignored. Then rst=0 mid-load: the next
//    edge gives IDLE with all outputs 0. A start in READY drops ff_en/rdy on the next
//    edge and a full reload completes.

Source files
------------

// File: rtl/fpga_config_loader.sv
// -----------------------------------------------------------------------------
// fpga_config_loader
// Streams configuration frames into the fabric. Each frame is accepted over a
// valid/ready handshake and written into one config row. Once the final frame
// is written and a settle delay has passed, the fabric flip-flops are enabled.
// After a second delay the loader reports ready.
//
// Ports
//   clock       single clock, rising edge
//   rst         synchronous active-low reset
//   start       1-cycle pulse: begin a load (IDLE) or restart one (READY/ERROR)
//   bs_data     frame data
//   bs_valid    frame data valid
//   bs_last     final frame marker, qualified by bs_valid
//   bs_ready    loader accepts a frame this cycle
//   configs_in  registered frame data to the fabric
//   configs_en  one-hot row write strobe, all 0 outside WRITE
//   ff_en       fabric flip-flop enable
//   rdy         configuration complete, fabric running
//   busy        load in progress (PRE..ENABLE)
//   err         frame count mismatch, sticky until start or reset
// -----------------------------------------------------------------------------
module fpga_config_loader #(
   parameter int DATA_W     = 320,
   parameter int NUM_FRAMES = 172,
   parameter int PRE_WAIT   = 10,
   parameter int POST_WAIT  = 10,
   parameter int RDY_DELAY  = 10
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     bs_data,
   input  logic                  bs_valid,
   input  logic                  bs_last,
   output logic                  bs_ready,
   output logic [DATA_W-1:0]     configs_in,
   output logic [NUM_FRAMES-1:0] configs_en,
   output logic                  ff_en,
   output logic                  rdy,
   output logic                  busy,
   output logic                  err
);

   localparam int IDX_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int WAIT_A   = (PRE_WAIT > POST_WAIT) ? PRE_WAIT : POST_WAIT;
   localparam int WAIT_MAX = (WAIT_A > RDY_DELAY) ? WAIT_A : RDY_DELAY;
   localparam int CNT_W    = $clog2(WAIT_MAX + 1);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_FRAMES - 1);
   localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(PRE_WAIT - 1);
   localparam logic [CNT_W-1:0] POST_END  = CNT_W'(POST_WAIT - 1);
   localparam logic [CNT_W-1:0] RDY_END   = CNT_W'(RDY_DELAY - 1);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_PRE    = 4'd1;
   localparam logic [3:0] S_FETCH  = 4'd2;
   localparam logic [3:0] S_SETUP  = 4'd3;
   localparam logic [3:0] S_WRITE  = 4'd4;
   localparam logic [3:0] S_POST   = 4'd5;
   localparam logic [3:0] S_ENABLE = 4'd6;
   localparam logic [3:0] S_READY  = 4'd7;
   localparam logic [3:0] S_ERROR  = 4'd8;

   logic [3:0]            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic [DATA_W-1:0]     cin_q, cin_d;
   logic [NUM_FRAMES-1:0] en_q, en_d;
   logic                  ff_en_q, ff_en_d;
   logic                  rdy_q, rdy_d;
   logic                  err_q, err_d;
   logic                  bs_ready_q, bs_ready_d;
   logic                  busy_q, busy_d;
   logic [NUM_FRAMES-1:0] row_sel;

   // Row decoder on the next-state index, so the strobe is registered
   // together with the WRITE state it belongs to.
   generate
      for (genvar gi = 0; gi < NUM_FRAMES; gi++) begin : g_row
         assign row_sel[gi] = (idx_d == IDX_W'(gi));
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      cin_d   = cin_q;
      ff_en_d = ff_en_q;
      rdy_d   = rdy_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_PRE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         S_PRE: begin
            if (cnt_q == PRE_END) begin
               state_d = S_FETCH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FETCH: begin
            // bs_ready_q is high exactly while in FETCH, so this is the handshake
            if (bs_valid && bs_ready_q) begin
               cin_d   = bs_data;
               last_d  = bs_last;
               state_d = S_SETUP;
            end
         end
         S_SETUP: state_d = S_WRITE;
         S_WRITE: begin
            if (idx_q == LAST_IDX && last_q) begin
               state_d = S_POST;
               cnt_d   = '0;
            end else if (idx_q < LAST_IDX && !last_q) begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_FETCH;
            end else begin
               // Short or long stream: the row has already been written,
               // but the fabric is never enabled on a partial bitstream.
               state_d = S_ERROR;
               err_d   = 1'b1;
            end
         end
         S_POST: begin
            if (cnt_q == POST_END) begin
               state_d = S_ENABLE;
               ff_en_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ENABLE: begin
            if (cnt_q == RDY_END) begin
               state_d = S_READY;
               rdy_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_READY, S_ERROR: begin
            if (start) begin
               state_d = S_PRE;
               idx_d   = '0;
               cnt_d   = '0;
               ff_en_d = 1'b0;
               rdy_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      bs_ready_d = (state_d == S_FETCH);
      busy_d     = (state_d == S_PRE)   || (state_d == S_FETCH) ||
                   (state_d == S_SETUP) || (state_d == S_WRITE) ||
                   (state_d == S_POST)  || (state_d == S_ENABLE);
      en_d       = (state_d == S_WRITE) ? row_sel : '0;
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         cin_q      <= '0;
         en_q       <= '0;
         ff_en_q    <= 1'b0;
         rdy_q      <= 1'b0;
         err_q      <= 1'b0;
         bs_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         cin_q      <= cin_d;
         en_q       <= en_d;
         ff_en_q    <= ff_en_d;
         rdy_q      <= rdy_d;
         err_q      <= err_d;
         bs_ready_q <= bs_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign bs_ready   = bs_ready_q;
   assign configs_in = cin_q;
   assign configs_en = en_q;
   assign ff_en      = ff_en_q;
   assign rdy        = rdy_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// -----------------------------------------------------------------------------
// tb_fpga_config_loader
// Directed scenarios for fpga_config_loader (DATA_W=8, NUM_FRAMES=4,
// PRE_WAIT=2, POST_WAIT=3, RDY_DELAY=2). Stimulus pushes expected row writes
// and expected output snapshots into queues; a negedge monitor pops and
// compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_fpga_config_loader;

   localparam int DW = 8;
   localparam int NF = 4;

   logic          clock = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] bs_data;
   logic          bs_valid;
   logic          bs_last;
   logic          bs_ready;
   logic [DW-1:0] configs_in;
   logic [NF-1:0] configs_en;
   logic          ff_en;
   logic          rdy;
   logic          busy;
   logic          err;

   always #5 clock = ~clock;

   fpga_config_loader #(
      .DATA_W(DW), .NUM_FRAMES(NF), .PRE_WAIT(2), .POST_WAIT(3), .RDY_DELAY(2)
   ) dut (
      .clock(clock), .rst(rst), .start(start),
      .bs_data(bs_data), .bs_valid(bs_valid), .bs_last(bs_last),
      .bs_ready(bs_ready), .configs_in(configs_in), .configs_en(configs_en),
      .ff_en(ff_en), .rdy(rdy), .busy(busy), .err(err)
   );

   // Snapshot layout: {configs_en, ff_en, rdy, err, busy, bs_ready}
   typedef struct {
      string      name;
      logic [8:0] exp;
      logic [8:0] mask;
      bit         chk_cin;
      logic [7:0] cin;
      bit         chk_drain;
   } probe_t;

   typedef struct {
      logic [3:0] en;
      logic [7:0] data;
   } wr_t;

   probe_t     probe_q[$];
   wr_t        wr_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] frames [4];

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      probe_t     p;
      wr_t        w;
      logic [8:0] act;
      act = {configs_en, ff_en, rdy, err, busy, bs_ready};
      while (probe_q.size() > 0) begin
         p = probe_q.pop_front();
         if (p.chk_drain) begin
            n_checks++;
            if (wr_q.size() == 0) n_pass++;
            else $display("FAIL %s: %0d writes outstanding, required 0", p.name, wr_q.size());
         end else begin
            n_checks++;
            if ((act & p.mask) === (p.exp & p.mask)) n_pass++;
            else $display("FAIL %s: {en,ff_en,rdy,err,busy,bs_ready}=%b required %b (mask %b)",
                          p.name, act, p.exp, p.mask);
            if (p.chk_cin) begin
               n_checks++;
               if (configs_in === p.cin) n_pass++;
               else $display("FAIL %s_cin: configs_in=%h required %h", p.name, configs_in, p.cin);
            end
         end
      end
      if (configs_en !== 4'b0000 && !$isunknown(configs_en)) begin
         n_checks++;
         if (wr_q.size() == 0) begin
            $display("FAIL write_unexpected: configs_en=%b configs_in=%h required no write",
                     configs_en, configs_in);
         end else begin
            w = wr_q.pop_front();
            if (configs_en === w.en && configs_in === w.data) begin
               n_pass++;
               $display("write en=%b data=%h ok", configs_en, configs_in);
            end else begin
               $display("FAIL write: en=%b data=%h required en=%b data=%h",
                        configs_en, configs_in, w.en, w.data);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic probe(input string name, input logic [3:0] en, input logic f,
                        input logic r, input logic e, input logic b, input logic br);
      probe_t p;
      p.name = name; p.exp = {en, f, r, e, b, br}; p.mask = 9'h1FF;
      p.chk_cin = 1'b0; p.cin = 8'h00; p.chk_drain = 1'b0;
      probe_q.push_back(p);
   endtask

   task automatic probe_cin(input string name, input logic [3:0] en, input logic f,
                            input logic r, input logic e, input logic b, input logic br,
                            input logic [7:0] cin);
      probe_t p;
      p.name = name; p.exp = {en, f, r, e, b, br}; p.mask = 9'h1FF;
      p.chk_cin = 1'b1; p.cin = cin; p.chk_drain = 1'b0;
      probe_q.push_back(p);
   endtask

   task automatic push_wr(input logic [3:0] en, input logic [7:0] data);
      wr_t w;
      w.en = en; w.data = data;
      wr_q.push_back(w);
   endtask

   // Presents frames[0..n-1]; bs_last on index last_at (-1: never).
   // Acceptance is judged from the handshake seen before each edge.
   task automatic drive_stream(input int n, input int last_at, input bit toggle);
      int     i   = 0;
      int     cyc = 0;
      bit     ph  = 1'b1;
      logic   acc;
      probe_t p;
      while (i < n && cyc < 100) begin
         bs_valid = toggle ? ph : 1'b1;
         bs_data  = frames[i];
         bs_last  = (i == last_at);
         @(negedge clock);
         acc = bs_valid && bs_ready;
         @(posedge clock);
         #1;
         if (acc) i++;
         ph = ~ph;
         cyc++;
      end
      bs_valid = 1'b0;
      bs_last  = 1'b0;
      if (i < n) begin
         p.name = "stream_timeout"; p.exp = 9'b0_0000_0001; p.mask = 9'b0_0000_0001;
         p.chk_cin = 1'b0; p.cin = 8'h00; p.chk_drain = 1'b0;
         probe_q.push_back(p);
      end
   endtask

   task automatic start_pulse();
      start = 1'b1;
      step();
      start = 1'b0;
      probe("restart", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Called in the cycle after the last frame was accepted (SETUP).
   task automatic post_timing();
      probe("setup_last", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(); probe_cin("write_last", 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA4);
      for (int k = 0; k < 3; k++) begin
         step(); probe("post_wait", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      step(); probe("ff_en_rise", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(); probe("enable_wait", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(); probe_cin("rdy_rise", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA4);
      step(); probe("ready_hold", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic full_load(input bit toggle);
      push_wr(4'b0001, 8'hA1);
      push_wr(4'b0010, 8'hA2);
      push_wr(4'b0100, 8'hA3);
      push_wr(4'b1000, 8'hA4);
      start_pulse();
      drive_stream(4, 3, toggle);
      post_timing();
   endtask

   // ---------------- scenarios ----------------
   initial begin
      frames[0] = 8'hA1; frames[1] = 8'hA2; frames[2] = 8'hA3; frames[3] = 8'hA4;
      rst = 1'b0; start = 1'b1; bs_data = 8'h5A; bs_valid = 1'b1; bs_last = 1'b0;

      // 1: reset held with start asserted
      for (int k = 0; k < 3; k++) begin
         step();
         probe_cin("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      rst = 1'b1; start = 1'b0; bs_valid = 1'b0;
      step();
      probe_cin("idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // 2: nominal, bs_valid held
      full_load(1'b0);

      // 3: backpressure, bs_valid toggling
      full_load(1'b1);

      // 4: short stream, last on second frame
      push_wr(4'b0001, 8'hA1);
      push_wr(4'b0010, 8'hA2);
      start_pulse();
      drive_stream(2, 1, 1'b0);
      probe("short_setup", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(); probe_cin("short_write", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA2);
      step(); probe("short_err", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) step();
      probe("short_err_held", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      full_load(1'b0);

      // 5: long stream, no last on fourth frame
      push_wr(4'b0001, 8'hA1);
      push_wr(4'b0010, 8'hA2);
      push_wr(4'b0100, 8'hA3);
      push_wr(4'b1000, 8'hA4);
      start_pulse();
      drive_stream(4, -1, 1'b0);
      probe("long_setup", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(); probe("long_write", 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(); probe("long_err", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) step();
      probe("long_err_held", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // 6: start ignored in FETCH, reset mid-load, restart from READY
      push_wr(4'b0001, 8'hA1);
      push_wr(4'b0010, 8'hA2);
      start_pulse();
      step(); probe("pre_2nd", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(); probe("fetch", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      probe("start_ignored", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      drive_stream(2, -1, 1'b0);
      step(); probe_cin("mid_write", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA2);
      step(); probe("mid_fetch", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      rst = 1'b0;
      step();
      probe_cin("reset_mid", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      full_load(1'b0);
      full_load(1'b1);

      step();
      begin
         probe_t p;
         p.name = "drain"; p.exp = 9'h000; p.mask = 9'h000;
         p.chk_cin = 1'b0; p.cin = 8'h00; p.chk_drain = 1'b1;
         probe_q.push_back(p);
      end
      step();
      step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks so far %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
